multi_sec_timer: RTL and testbench
==================================

Name: multi_sec_timer

Overview:
- Parametrised, multi-channel successor to the single one-shot seconds counter used for game timing on the DE10 board.
- One shared prescaler generates a one-second tick; a turbo input makes that tick TURBO_DIV times faster.
- NUM_CH independent channels each count down a programmable number of seconds, in one-shot or periodic mode.
- Each channel exposes a one-cycle expiry pulse and its remaining-seconds value, for game logic such as spawn timers and level clocks.

Parameters:
- CLK_HZ, 50_000_000: clk cycles per second. Simulation uses 20.
- TURBO_DIV, 10: tick-rate multiplier when turbo=1. Integer, must be ≥1, and CLK_HZ/TURBO_DIV must be ≥2.
- NUM_CH, 4: number of timer channels, 1..16.
- SEC_W, 8: width of the per-channel seconds value.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- turbo  in  1  1 = prescaler top is CLK_HZ/TURBO_DIV
- start  in  NUM_CH  per-channel load-and-run strobe, level sampled each clk
- stop  in  NUM_CH  per-channel abort strobe
- periodic  in  NUM_CH  mode, sampled at start and at each expiry: 1 = auto-reload, 0 = one-shot
- period_sec  in  NUM_CH*SEC_W  packed per-channel period in seconds; channel i occupies bits [i*SEC_W +: SEC_W]
- sec_tick  out  1  one-cycle pulse per (possibly turbo) second
- running  out  NUM_CH  channel is counting
- expired  out  NUM_CH  one-cycle pulse when a channel reaches zero
- remaining  out  NUM_CH*SEC_W  packed seconds left; same packing as period_sec

Behaviour:
- Reset (async, resetN=0): prescaler count=0; sec_tick=0; all channels IDLE; running=0, expired=0, remaining=0.
- Prescaler:
  - TOP = turbo ? CLK_HZ/TURBO_DIV : CLK_HZ, computed at elaboration as two constants muxed by turbo.
  - Count width is $clog2(CLK_HZ).
  - Each clk: if count ≥ TOP-1 then count←0 and sec_tick←1 (registered); else count+1 and sec_tick←0.
  - The ≥ comparison covers a turbo 0→1 switch when count is already above the new TOP: the tick fires on the next cycle, with no wrap-around wait.
  - Period is exactly TOP cycles between sec_tick pulses when turbo is stable.
  - The prescaler is free-running and is not restarted by channel start. The first second of a channel is therefore 1..TOP cycles long (documented jitter).
- Channel FSM, states IDLE and RUN. Priority per cycle: stop > start > sec_tick.
  - stop=1 (any state): → IDLE, remaining←0, running←0, no expired pulse.
  - start=1 with period_sec≠0 (any state, i.e. restart allowed): → RUN, remaining←period_sec, running←1. A coincident sec_tick does not decrement.
  - start=1 with period_sec=0: expired←1 next cycle, → IDLE, remaining←0, running←0, regardless of periodic.
  - RUN with sec_tick and remaining>1: remaining←remaining-1.
  - RUN with sec_tick and remaining==1: expired←1 for one cycle.
    - periodic=1 and period_sec≠0: remaining←period_sec, stay RUN.
    - otherwise: remaining←0, → IDLE, running←0.
  - IDLE ignores sec_tick.
- All outputs are registered. expired is high in the cycle after the sec_tick (or start) that caused it.
- Channels are fully independent. Several channels may expire in the same cycle.
- Arithmetic is unsigned. remaining never underflows.

Decomposition:
- Package multi_sec_timer_pkg: ch_state_t enum {IDLE, RUN}, DE10_CLK_HZ=50_000_000, SIM_CLK_HZ=20.
- Sub-module sec_prescaler (clk, resetN, turbo → sec_tick), parametrised by CLK_HZ and TURBO_DIV.
- Channels are a generate loop in the top module.

Test Plan (CLK_HZ=20, TURBO_DIV=10, NUM_CH=4, SEC_W=8):
- Reset release, turbo=0 → sec_tick pulses every 20 cycles; with turbo=1 → every 2 cycles; all channel outputs 0 throughout reset.
- Ch0 one-shot, period_sec=3, start pulse → remaining 3,2,1 on successive ticks; expired[0] pulses one cycle after the third tick; running[0]→0, remaining[0]=0.
- Ch1 periodic, period 2 → expired[1] pulses every 40 cycles (turbo=0) for ≥3 periods; remaining follows 2,1,2,1…; running[1] stays 1.
- Ch2 start and stop asserted in the same cycle → stays IDLE, no expired. Start then stop mid-count at remaining=5 → remaining=0, no pulse. Restart mid-count → reloads to full period.
- Ch3 start with period_sec=0 → single expired pulse next cycle, running stays 0. Start coincident with sec_tick → remaining equals period, not period-1.
- Turbo switched 0→1 while count=15 → sec_tick on the next cycle, then every 2 cycles; all four channels expiring in the same cycle → expired=4'b1111 for exactly one cycle.

Source files
------------

// File: rtl/multi_sec_timer_pkg.sv
// Shared types and clock constants for the multi-channel seconds timer.
package multi_sec_timer_pkg;

   typedef enum logic {IDLE, RUN} ch_state_t;

   localparam int DE10_CLK_HZ = 50_000_000;
   localparam int SIM_CLK_HZ  = 20;

endpackage

// File: rtl/sec_prescaler.sv
// Free-running prescaler producing a registered one-cycle tick per (turbo) second.
module sec_prescaler #(
   parameter int CLK_HZ    = 50_000_000,
   parameter int TURBO_DIV = 10
) (
   input  logic clk,
   input  logic resetN,
   input  logic turbo,
   output logic sec_tick
);

   localparam int CW = $clog2(CLK_HZ);
   localparam logic [CW-1:0] TOP_NORM_M1  = CW'(CLK_HZ - 1);
   localparam logic [CW-1:0] TOP_TURBO_M1 = CW'(CLK_HZ / TURBO_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;
   logic [CW-1:0] top_m1;

   assign top_m1 = turbo ? TOP_TURBO_M1 : TOP_NORM_M1;

   // >= rather than == so a turbo switch with the count already past the new
   // top fires immediately instead of waiting for the counter to wrap.
   always_comb begin
      cnt_d  = cnt_q + CW'(1);
      tick_d = 1'b0;
      if (cnt_q >= top_m1) begin
         cnt_d  = '0;
         tick_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign sec_tick = tick_q;

endmodule

// File: rtl/multi_sec_timer.sv
// NUM_CH independent one-shot/periodic seconds countdowns sharing one prescaler.
module multi_sec_timer
   import multi_sec_timer_pkg::*;
#(
   parameter int CLK_HZ    = DE10_CLK_HZ,
   parameter int TURBO_DIV = 10,
   parameter int NUM_CH    = 4,
   parameter int SEC_W     = 8
) (
   input  logic                    clk,
   input  logic                    resetN,
   input  logic                    turbo,
   input  logic [NUM_CH-1:0]       start,
   input  logic [NUM_CH-1:0]       stop,
   input  logic [NUM_CH-1:0]       periodic,
   input  logic [NUM_CH*SEC_W-1:0] period_sec,
   output logic                    sec_tick,
   output logic [NUM_CH-1:0]       running,
   output logic [NUM_CH-1:0]       expired,
   output logic [NUM_CH*SEC_W-1:0] remaining
);

   sec_prescaler #(
      .CLK_HZ    (CLK_HZ),
      .TURBO_DIV (TURBO_DIV)
   ) u_presc (
      .clk      (clk),
      .resetN   (resetN),
      .turbo    (turbo),
      .sec_tick (sec_tick)
   );

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      ch_state_t        st_q, st_d;
      logic [SEC_W-1:0] rem_q, rem_d;
      logic             exp_q, exp_d;
      logic [SEC_W-1:0] per;

      assign per = period_sec[g*SEC_W +: SEC_W];

      // Priority: stop, then start (restart allowed), then the second tick.
      always_comb begin
         st_d  = st_q;
         rem_d = rem_q;
         exp_d = 1'b0;
         if (stop[g]) begin
            st_d  = IDLE;
            rem_d = '0;
         end else if (start[g]) begin
            if (per != '0) begin
               st_d  = RUN;
               rem_d = per;
            end else begin
               st_d  = IDLE;
               rem_d = '0;
               exp_d = 1'b1;
            end
         end else if (st_q == RUN && sec_tick) begin
            if (rem_q > SEC_W'(1)) begin
               rem_d = rem_q - SEC_W'(1);
            end else begin
               exp_d = 1'b1;
               if (periodic[g] && per != '0) begin
                  rem_d = per;
               end else begin
                  st_d  = IDLE;
                  rem_d = '0;
               end
            end
         end
      end

      always_ff @(posedge clk or negedge resetN) begin
         if (!resetN) begin
            st_q  <= IDLE;
            rem_q <= '0;
            exp_q <= 1'b0;
         end else begin
            st_q  <= st_d;
            rem_q <= rem_d;
            exp_q <= exp_d;
         end
      end

      assign running[g]                  = (st_q == RUN);
      assign expired[g]                  = exp_q;
      assign remaining[g*SEC_W +: SEC_W] = rem_q;
   end

endmodule

// File: tb/tb_multi_sec_timer.sv
// Directed bench for multi_sec_timer at CLK_HZ=20, TURBO_DIV=10, four channels.
module tb_multi_sec_timer;
   import multi_sec_timer_pkg::*;

   localparam int NCH = 4;
   localparam int SW  = 8;

   logic              clk = 1'b0;
   logic              resetN;
   logic              turbo;
   logic [NCH-1:0]    start, stop, periodic;
   logic [NCH*SW-1:0] period_sec;
   logic              sec_tick;
   logic [NCH-1:0]    running, expired;
   logic [NCH*SW-1:0] remaining;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int t_exp;
   int n;

   multi_sec_timer #(
      .CLK_HZ    (SIM_CLK_HZ),
      .TURBO_DIV (10),
      .NUM_CH    (NCH),
      .SEC_W     (SW)
   ) dut (
      .clk        (clk),
      .resetN     (resetN),
      .turbo      (turbo),
      .start      (start),
      .stop       (stop),
      .periodic   (periodic),
      .period_sec (period_sec),
      .sec_tick   (sec_tick),
      .running    (running),
      .expired    (expired),
      .remaining  (remaining)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [SW-1:0] rem(input int i);
      return remaining[i*SW +: SW];
   endfunction

   task automatic set_per(input int i, input logic [SW-1:0] v);
      period_sec[i*SW +: SW] = v;
   endtask

   // Steps at least once, stops on the sample where sec_tick is high.
   task automatic wait_tick(output int cnt);
      cnt = 0;
      do begin
         step();
         cnt++;
      end while (!sec_tick && cnt < 100);
      if (!sec_tick) chk("tick_timeout", 0, 1);
   endtask

   initial begin
      resetN     = 1'b0;
      turbo      = 1'b0;
      start      = '1;
      stop       = '0;
      periodic   = '0;
      period_sec = {4{8'd3}};

      // reset holds everything at zero even with start asserted
      repeat (5) step();
      chk("rst_tick", sec_tick, 0);
      chk("rst_running", running, 0);
      chk("rst_expired", expired, 0);
      chk("rst_remaining", remaining, 0);
      start  = '0;
      resetN = 1'b1;

      // prescaler period, normal then turbo
      wait_tick(n);
      wait_tick(n); chk("period_norm_a", n, 20);
      wait_tick(n); chk("period_norm_b", n, 20);
      turbo = 1'b1;
      wait_tick(n); chk("period_turbo_first", n, 2);
      wait_tick(n); chk("period_turbo_a", n, 2);
      wait_tick(n); chk("period_turbo_b", n, 2);
      turbo = 1'b0;
      wait_tick(n);

      // ch0 one-shot, 3 seconds
      step();
      set_per(0, 8'd3); start[0] = 1'b1;
      step(); start[0] = 1'b0;
      chk("c0_load_rem", rem(0), 3);
      chk("c0_load_run", running[0], 1);
      wait_tick(n); step(); chk("c0_rem2", rem(0), 2);
      wait_tick(n); step(); chk("c0_rem1", rem(0), 1);
      wait_tick(n);
      chk("c0_no_early_exp", expired[0], 0);
      step();
      chk("c0_exp", expired, 4'b0001);
      chk("c0_idle", running[0], 0);
      chk("c0_rem0", rem(0), 0);
      step();
      chk("c0_exp_1cyc", expired[0], 0);

      // ch1 periodic, 2 seconds: 1,2,1,2... with a pulse every 40 cycles
      set_per(1, 8'd2); periodic[1] = 1'b1; start[1] = 1'b1;
      step(); start[1] = 1'b0;
      chk("c1_load_rem", rem(1), 2);
      t_exp = 0;
      for (int k = 0; k < 6; k++) begin
         wait_tick(n); step();
         chk($sformatf("c1_rem_k%0d", k), rem(1), (k % 2 == 0) ? 1 : 2);
         chk($sformatf("c1_exp_k%0d", k), expired[1], (k % 2 == 1) ? 1 : 0);
         chk($sformatf("c1_run_k%0d", k), running[1], 1);
         if (k % 2 == 1) begin
            if (k > 1) chk($sformatf("c1_interval_k%0d", k), cyc - t_exp, 40);
            t_exp = cyc;
         end
      end
      stop[1] = 1'b1; step(); stop[1] = 1'b0;
      chk("c1_stopped", running[1], 0);

      // ch2 start+stop together, stop mid-count, restart mid-count
      set_per(2, 8'd7); start[2] = 1'b1; stop[2] = 1'b1;
      step(); start[2] = 1'b0; stop[2] = 1'b0;
      chk("c2_ss_run", running[2], 0);
      chk("c2_ss_rem", rem(2), 0);
      chk("c2_ss_exp", expired[2], 0);
      wait_tick(n); step();
      start[2] = 1'b1; step(); start[2] = 1'b0;
      chk("c2_load", rem(2), 7);
      wait_tick(n); step(); chk("c2_rem6", rem(2), 6);
      wait_tick(n); step(); chk("c2_rem5", rem(2), 5);
      stop[2] = 1'b1; step(); stop[2] = 1'b0;
      chk("c2_stop_rem", rem(2), 0);
      chk("c2_stop_run", running[2], 0);
      chk("c2_stop_exp", expired[2], 0);
      step();
      chk("c2_stop_exp_late", expired[2], 0);
      start[2] = 1'b1; step(); start[2] = 1'b0;
      wait_tick(n); step();
      wait_tick(n); step(); chk("c2_pre_restart", rem(2), 5);
      start[2] = 1'b1; step(); start[2] = 1'b0;
      chk("c2_restart", rem(2), 7);
      stop[2] = 1'b1; step(); stop[2] = 1'b0;

      // ch3 zero period, then start coincident with a tick
      set_per(3, 8'd0); start[3] = 1'b1;
      step(); start[3] = 1'b0;
      chk("c3_zero_exp", expired, 4'b1000);
      chk("c3_zero_run", running[3], 0);
      step();
      chk("c3_zero_exp_1cyc", expired[3], 0);
      set_per(3, 8'd5);
      wait_tick(n);
      start[3] = 1'b1; step(); start[3] = 1'b0;
      chk("c3_tick_load", rem(3), 5);
      stop[3] = 1'b1; step(); stop[3] = 1'b0;

      // turbo switch at count 15, then all channels expire together
      wait_tick(n);
      repeat (15) step();
      chk("tsw_no_tick", sec_tick, 0);
      turbo = 1'b1;
      step(); chk("tsw_tick_next", sec_tick, 1);
      step(); chk("tsw_gap", sec_tick, 0);
      step(); chk("tsw_tick2", sec_tick, 1);
      step();
      periodic   = '0;
      period_sec = {4{8'd2}};
      start      = '1;
      step(); start = '0;
      chk("all_load", remaining, {4{8'd2}});
      step(); chk("all_rem1", remaining, {4{8'd1}});
      chk("all_no_exp", expired, 0);
      step();
      step(); chk("all_exp", expired, 4'b1111);
      chk("all_idle", running, 0);
      chk("all_rem0", remaining, 0);
      step(); chk("all_exp_1cyc", expired, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
